// File: rtl/i2c_target_rx_if.sv
// -----------------------------------------------------------------------------
// i2c_target_rx_if
// Bundles the pad-side I2C lines and the downstream byte handshake of the
// write-only I2C target receiver.
//   scl_in / sda_in : pad levels seen by the target
//   scl_oe / sda_oe : 1 = target pulls the line low (stretch / ACK)
//   rx_data, rx_valid, rx_first, rx_ready : received-byte valid/ready handshake
//   busy            : target addressed, transfer in progress
// Modports: slave = the target receiver, master = bus side / environment.
// -----------------------------------------------------------------------------
interface i2c_target_rx_if;
   logic       scl_in;
   logic       sda_in;
   logic       scl_oe;
   logic       sda_oe;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;
   logic       rx_first;
   logic       busy;

   modport slave (
      input  scl_in, sda_in, rx_ready,
      output scl_oe, sda_oe, rx_data, rx_valid, rx_first, busy
   );

   modport master (
      output scl_in, sda_in, rx_ready,
      input  scl_oe, sda_oe, rx_data, rx_valid, rx_first, busy
   );
endinterface

// File: rtl/i2c_target_rx.sv
// -----------------------------------------------------------------------------
// i2c_target_rx
// Write-only I2C target. Detects START/STOP, matches a 7-bit address (write
// only), shifts data bytes in MSB first, ACKs every byte and stretches SCL low
// until the downstream logic accepts the byte.
// Ports:
//   clk  : system clock, at least 8x the SCL rate
//   rst  : asynchronous, active-high reset
//   bus  : i2c_target_rx_if.slave (pad lines, open-drain enables, rx handshake)
// Parameters:
//   ADDR        : 7-bit target address
//   SYNC_STAGES : synchroniser depth for scl_in/sda_in (minimum 2)
// -----------------------------------------------------------------------------
module i2c_target_rx #(
   parameter logic [6:0] ADDR        = 7'h42,
   parameter int          SYNC_STAGES = 2
) (
   input logic             clk,
   input logic             rst,
   i2c_target_rx_if.slave  bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR,
      S_ADDR_ACK,
      S_DATA,
      S_STRETCH,
      S_DATA_ACK,
      S_IGNORE
   } state_t;

   // ---------------------------------------------------------------------------
   // Input synchronisers plus one registered copy for edge detection.
   // Reset to 1 so that leaving reset on an idle bus produces no false edges.
   // ---------------------------------------------------------------------------
   logic [SYNC_STAGES-1:0] r_scl_sync;
   logic [SYNC_STAGES-1:0] r_sda_sync;
   logic                   r_scl_d;
   logic                   r_sda_d;

   // NOTE: sequential state is assigned with non-blocking (<=) only, so every
   // flop samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_scl_sync <= '1;
         r_sda_sync <= '1;
         r_scl_d    <= 1'b1;
         r_sda_d    <= 1'b1;
      end else begin
         r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], bus.scl_in};
         r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], bus.sda_in};
         r_scl_d    <= r_scl_sync[SYNC_STAGES-1];
         r_sda_d    <= r_sda_sync[SYNC_STAGES-1];
      end
   end

   logic w_scl_s;
   logic w_sda_s;
   logic w_scl_rise;
   logic w_scl_fall;
   logic w_start;
   logic w_stop;

   assign w_scl_s    = r_scl_sync[SYNC_STAGES-1];
   assign w_sda_s    = r_sda_sync[SYNC_STAGES-1];
   assign w_scl_rise =  w_scl_s & ~r_scl_d;
   assign w_scl_fall = ~w_scl_s &  r_scl_d;
   assign w_start    =  w_scl_s & ~w_sda_s &  r_sda_d;
   assign w_stop     =  w_scl_s &  w_sda_s & ~r_sda_d;

   // ---------------------------------------------------------------------------
   // Protocol FSM with registered outputs
   // ---------------------------------------------------------------------------
   state_t     r_state;
   logic [3:0] r_bit_cnt;
   logic [7:0] r_shift;
   logic       r_first_flag;   // next data byte is the first after the address
   logic       r_pending;      // byte complete in r_shift, rx_data still occupied
   logic       r_scl_oe;
   logic       r_sda_oe;
   logic [7:0] r_rx_data;
   logic       r_rx_valid;
   logic       r_rx_first;
   logic       r_busy;

   logic [7:0] w_byte;
   logic       w_rx_fire;

   assign w_byte    = {r_shift[6:0], w_sda_s};
   assign w_rx_fire = r_rx_valid & bus.rx_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: the data-path registers are reset too; they are few, and this
         // keeps rx_data at a defined 0 after reset as downstream expects.
         r_state      <= S_IDLE;
         r_bit_cnt    <= 4'd0;
         r_shift      <= 8'h00;
         r_first_flag <= 1'b0;
         r_pending    <= 1'b0;
         r_scl_oe     <= 1'b0;
         r_sda_oe     <= 1'b0;
         r_rx_data    <= 8'h00;
         r_rx_valid   <= 1'b0;
         r_rx_first   <= 1'b0;
         r_busy       <= 1'b0;
      end else begin
         // Downstream handshake
         if (w_rx_fire) begin
            r_rx_valid <= 1'b0;
            r_rx_first <= 1'b0;
         end

         // A byte completed while rx_data was occupied is loaded once it frees
         if (r_pending && !r_rx_valid) begin
            r_rx_data    <= r_shift;
            r_rx_valid   <= 1'b1;
            r_rx_first   <= r_first_flag;
            r_first_flag <= 1'b0;
            r_pending    <= 1'b0;
         end

         if (w_start) begin
            r_state   <= S_ADDR;
            r_bit_cnt <= 4'd0;
            r_sda_oe  <= 1'b0;
            r_scl_oe  <= 1'b0;
            r_pending <= 1'b0;
         end else if (w_stop) begin
            r_state   <= S_IDLE;
            r_sda_oe  <= 1'b0;
            r_scl_oe  <= 1'b0;
            r_busy    <= 1'b0;
            r_pending <= 1'b0;
         end else begin
            case (r_state)
               S_ADDR: begin
                  if (w_scl_rise) begin
                     r_shift   <= w_byte;
                     r_bit_cnt <= r_bit_cnt + 4'd1;
                     if (r_bit_cnt == 4'd7) begin
                        if (w_byte[7:1] == ADDR && !w_byte[0]) begin
                           r_state      <= S_ADDR_ACK;
                           r_busy       <= 1'b1;
                           r_first_flag <= 1'b1;
                        end else begin
                           r_state <= S_IGNORE;
                        end
                     end
                  end
               end

               // First fall: drive ACK for the 9th bit; second fall: release.
               S_ADDR_ACK: begin
                  if (w_scl_fall) begin
                     if (!r_sda_oe) begin
                        r_sda_oe <= 1'b1;
                     end else begin
                        r_sda_oe  <= 1'b0;
                        r_state   <= S_DATA;
                        r_bit_cnt <= 4'd0;
                     end
                  end
               end

               S_DATA: begin
                  if (w_scl_rise && r_bit_cnt < 4'd8) begin
                     r_shift   <= w_byte;
                     r_bit_cnt <= r_bit_cnt + 4'd1;
                     if (r_bit_cnt == 4'd7) begin
                        if (!r_rx_valid) begin
                           r_rx_data    <= w_byte;
                           r_rx_valid   <= 1'b1;
                           r_rx_first   <= r_first_flag;
                           r_first_flag <= 1'b0;
                        end else begin
                           r_pending <= 1'b1;
                        end
                     end
                  end else if (w_scl_fall && r_bit_cnt == 4'd8) begin
                     // SCL is already low here, so stretching cannot cause a
                     // fall of its own.
                     if (!r_rx_valid && !r_pending) begin
                        r_sda_oe <= 1'b1;
                        r_state  <= S_DATA_ACK;
                     end else begin
                        r_scl_oe <= 1'b1;
                        r_state  <= S_STRETCH;
                     end
                  end
               end

               // ACK is set up one clk before SCL is released.
               S_STRETCH: begin
                  if (r_sda_oe) begin
                     r_scl_oe <= 1'b0;
                     r_state  <= S_DATA_ACK;
                  end else if (!r_pending && (!r_rx_valid || bus.rx_ready)) begin
                     r_sda_oe <= 1'b1;
                  end
               end

               S_DATA_ACK: begin
                  if (w_scl_fall) begin
                     r_sda_oe  <= 1'b0;
                     r_state   <= S_DATA;
                     r_bit_cnt <= 4'd0;
                  end
               end

               default: ;  // S_IDLE, S_IGNORE: wait for START/STOP
            endcase
         end
      end
   end

   assign bus.scl_oe   = r_scl_oe;
   assign bus.sda_oe   = r_sda_oe;
   assign bus.rx_data  = r_rx_data;
   assign bus.rx_valid = r_rx_valid;
   assign bus.rx_first = r_rx_first;
   assign bus.busy     = r_busy;

endmodule

// File: doc/i2c_target_rx.md
Name: i2c_target_rx

Overview:
- Write-only I2C target (slave) receiver; the far end of the bus from our I2C master clock generator.
- Detects START/STOP, matches a 7-bit address and shifts in data bytes MSB first.
- ACKs each byte and stretches SCL low until downstream logic accepts the byte over a valid/ready handshake.
- Sits between the open-drain pad wrappers and the register/command logic.

Parameters:
- ADDR, 7'h42, 7-bit target address to respond to.
- SYNC_STAGES, 2, flop stages synchronising scl_in/sda_in (minimum 2).

Ports:
- clk  input  1  system clock; must be at least 8x the SCL rate.
- rst  input  1  asynchronous, active-high reset.
- scl_in  input  1  SCL pad level.
- sda_in  input  1  SDA pad level.
- scl_oe  output  1  1 = pull SCL low (stretch).
- sda_oe  output  1  1 = pull SDA low (ACK).
- rx_data  output  8  received data byte.
- rx_valid  output  1  rx_data valid; held until accepted.
- rx_ready  input  1  downstream accepts when rx_valid && rx_ready.
- rx_first  output  1  qualifies rx_valid: first data byte after the address byte.
- busy  output  1  1 from an addressed START until STOP.

Behaviour:
- One clock domain on clk. rst is asynchronous, active-high.
- Reset values: scl_oe=0, sda_oe=0, rx_data=0, rx_valid=0, rx_first=0, busy=0. State is IDLE and the bit counter is 0.
- Reset mid-operation releases both bus lines on the reset assertion itself, without waiting for a clock edge.
- Input synchronisation: SYNC_STAGES-deep synchronisers feed one extra registered copy each. Edge detection compares that registered copy with the synchroniser output (scl_s, sda_s).
  - scl_rise = scl_s rising; scl_fall = scl_s falling.
  - START = sda_s falls while scl_s=1.
  - STOP = sda_s rises while scl_s=1.
- States: IDLE, ADDR, ADDR_ACK, DATA, STRETCH, DATA_ACK, IGNORE.
- START from any state:
  - Go to ADDR; bit counter=0.
  - Release sda_oe.
  - busy is unchanged; a pending rx_valid is kept and is not dropped.
- STOP from any state: go to IDLE, release sda_oe, busy=0.
- ADDR:
  - Shift sda_s on each scl_rise.
  - After the 8th bit: if bits[7:1]==ADDR and bit0==0 (write), go to ADDR_ACK, set busy=1 and set the first-byte flag.
  - Otherwise (address mismatch or read request) go to IGNORE with no ACK driven.
- ADDR_ACK:
  - On the next scl_fall, set sda_oe=1.
  - On the following scl_fall, set sda_oe=0 and go to DATA with bit counter=0.
- DATA: shift on scl_rise. On the 8th bit:
  - If rx_valid is clear, load rx_data and set rx_valid=1 in the same clk.
  - rx_first = first-byte flag; then clear the flag.
- At the scl_fall after the 8th bit:
  - If the byte has been accepted (rx_valid==0): set sda_oe=1 and go to DATA_ACK.
  - Otherwise set scl_oe=1 and go to STRETCH.
- STRETCH:
  - Hold scl_oe=1.
  - If the previous byte was still pending at the 8th bit, load the new byte the cycle after the previous byte is accepted, then continue waiting.
  - When rx_valid && rx_ready (and no byte remains unloaded): set sda_oe=1 with scl_oe held 1 for one more clk, then release scl_oe and go to DATA_ACK.
  - The ACK is therefore set up before SCL rises.
- DATA_ACK: on the next scl_fall, set sda_oe=0 and go to DATA with bit counter=0.
- Handshake:
  - rx_valid clears on the clk where rx_valid && rx_ready. rx_first clears with it.
  - rx_data is stable while rx_valid=1.
- IGNORE: outputs released; wait for START or STOP.
- scl_fall caused by our own scl_oe cannot occur, since scl_oe is only asserted after SCL is already low.
- No data loss: SCL is stretched until the byte is accepted.

Test Plan:
1. ADDR=0x42; master sends START, 0x84, 0xA5, STOP with rx_ready=1 -> sda_oe high during both 9th bits; one rx_valid pulse with rx_data=0xA5, rx_first=1; busy drops at STOP; scl_oe never asserted.
2. START, 0x86 (mismatch), 0x11, STOP -> sda_oe never asserted; rx_valid stays 0; busy stays 0.
3. START, 0x84, 0x3C with rx_ready=0 for 200 clks -> scl_oe=1 continuously from the 8th-bit SCL fall. After rx_ready=1: sda_oe=1 one clk before scl_oe drops, and rx_data=0x3C held throughout.
4. START, 0x84, 0x01, 0x02 with rx_ready=1 -> rx_first=1 for 0x01 only and 0 for 0x02.
5. START, 0x85 (read) -> NACK (sda_oe=0 at the 9th bit), state IGNORE. Repeated START, 0x84, 0x77 -> ACKed, rx_data=0x77.
6. Assert rst during STRETCH -> scl_oe, sda_oe, rx_valid and busy are 0 with no clk edge needed. STOP mid-byte after 4 data bits -> IDLE, no rx_valid.
